// File: rtl/ans_rans_encoder.sv
// ans_rans_encoder
//   Streaming rANS encoder. A frequency table is loaded one entry per
//   transaction, prefix-summed into cumulative frequencies, and then each
//   encoded symbol renormalises the coder state (emitting low-order digits),
//   divides the state by the symbol frequency, and folds quotient, remainder
//   and cumulative frequency back into the state. A flush emits the whole
//   state least-significant digit first and re-initialises it.
//
// Ports
//   clk       in   clock, all state on rising edge
//   rst       in   asynchronous active-high reset
//   cmd       in   2   00 clear, 01 encode, 10 flush, 11 load table entry
//   in_data   in   IN_WIDTH   symbol (low SYM_WIDTH) or frequency (low PREC+1)
//   in_vld    in   transaction valid
//   in_rdy    out  transaction accepted this cycle (IDLE/LOAD only)
//   out_data  out  OUT_WIDTH  emitted state digit
//   out_vld   out  out_data valid
//   out_rdy   in   downstream accepts digit
//   out_last  out  final digit of a flush
//   tbl_ok    out  table loaded and frequencies sum to 2^PREC
//   err       out  sticky error, cleared by cmd 00
module ans_rans_encoder #(
    parameter int SYM_WIDTH   = 4,
    parameter int PREC        = 4,
    parameter int STATE_WIDTH = 16,
    parameter int OUT_WIDTH   = 4,
    parameter int IN_WIDTH    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           cmd,
    input  logic [IN_WIDTH-1:0]  in_data,
    input  logic                 in_vld,
    output logic                 in_rdy,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic                 out_vld,
    input  logic                 out_rdy,
    output logic                 out_last,
    output logic                 tbl_ok,
    output logic                 err
);

    localparam int unsigned N    = 1 << SYM_WIDTH;
    localparam int          FW   = PREC + 1;
    localparam int          AW   = PREC + SYM_WIDTH + 1;
    localparam int          ND   = STATE_WIDTH / OUT_WIDTH;
    localparam int          CNTW = $clog2(STATE_WIDTH + 1);

    localparam logic [STATE_WIDTH-1:0] L_VAL    = STATE_WIDTH'(1) << (STATE_WIDTH - OUT_WIDTH);
    localparam logic [AW-1:0]          M_VAL    = AW'(1) << PREC;
    localparam logic [SYM_WIDTH-1:0]   PTR_LAST = SYM_WIDTH'(N - 1);
    localparam logic [CNTW-1:0]        DIV_LAST = CNTW'(STATE_WIDTH - 1);
    localparam logic [CNTW-1:0]        FL_LAST  = CNTW'(ND - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CUMSUM,
        S_RENORM,
        S_DIV,
        S_UPDATE,
        S_FLUSH
    } state_t;

    state_t                 r_state;
    state_t                 w_next;

    logic [STATE_WIDTH-1:0] r_x;
    logic [SYM_WIDTH-1:0]   r_ptr;
    logic [FW-1:0]          r_f [N];
    logic [FW-1:0]          r_c [N];
    logic [AW-1:0]          r_acc;
    logic [SYM_WIDTH-1:0]   r_sym;
    logic [STATE_WIDTH-1:0] r_q;
    logic [FW-1:0]          r_rem;
    logic [CNTW-1:0]        r_cnt;
    logic                   r_tbl_ok;
    logic                   r_err;

    logic                   w_rdy;
    logic                   w_in_fire;
    logic [SYM_WIDTH-1:0]   w_enc_sym;
    logic                   w_enc_ok;
    logic [AW-1:0]          w_acc_sum;
    logic [FW-1:0]          w_f_sym;
    logic [STATE_WIDTH:0]   w_x_max;
    logic                   w_renorm;
    logic [FW:0]            w_trial;
    logic [FW:0]            w_div_d;
    logic                   w_ge;
    logic [FW:0]            w_trial_sub;
    logic [STATE_WIDTH-1:0] w_upd;
    logic                   w_unused;

    assign w_rdy     = ((r_state == S_IDLE) || (r_state == S_LOAD)) && !rst;
    assign w_in_fire = in_vld && w_rdy;
    assign w_enc_sym = in_data[SYM_WIDTH-1:0];
    assign w_enc_ok  = r_tbl_ok && (r_f[w_enc_sym] != '0);
    assign w_acc_sum = r_acc + AW'(r_f[r_ptr]);

    // Renormalisation bound f[s] << (STATE_WIDTH-PREC); one extra bit so a
    // frequency of M (bound == 2^STATE_WIDTH) never triggers a digit.
    assign w_f_sym  = r_f[r_sym];
    assign w_x_max  = (STATE_WIDTH + 1)'(w_f_sym) << (STATE_WIDTH - PREC);
    assign w_renorm = {1'b0, r_x} >= w_x_max;

    // Restoring division: r_q starts as the dividend and shifts quotient
    // bits in from the right while the remainder absorbs its MSB.
    assign w_trial     = {r_rem, r_q[STATE_WIDTH-1]};
    assign w_div_d     = {1'b0, w_f_sym};
    assign w_ge        = w_trial >= w_div_d;
    assign w_trial_sub = w_trial - w_div_d;

    assign w_upd = (r_q << PREC) + STATE_WIDTH'(r_rem) + STATE_WIDTH'(r_c[r_sym]);

    assign tbl_ok   = r_tbl_ok;
    assign err      = r_err;
    assign w_unused = &{1'b0, in_data, w_trial_sub[FW]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        in_rdy   = 1'b0;
        out_vld  = 1'b0;
        out_last = 1'b0;
        out_data = '0;
        case (r_state)
            S_IDLE, S_LOAD: begin
                in_rdy = w_rdy;
                if (w_in_fire) begin
                    case (cmd)
                        2'b00:   w_next = S_IDLE;
                        2'b01:   w_next = w_enc_ok ? S_RENORM : S_IDLE;
                        2'b10:   w_next = S_FLUSH;
                        default: w_next = (r_ptr == PTR_LAST) ? S_CUMSUM : S_LOAD;
                    endcase
                end
            end
            S_CUMSUM: begin
                if (r_ptr == PTR_LAST) begin
                    w_next = S_IDLE;
                end
            end
            S_RENORM: begin
                if (w_renorm) begin
                    out_vld  = 1'b1;
                    out_data = r_x[OUT_WIDTH-1:0];
                end else begin
                    w_next = S_DIV;
                end
            end
            S_DIV: begin
                if (r_cnt == DIV_LAST) begin
                    w_next = S_UPDATE;
                end
            end
            S_UPDATE: begin
                w_next = S_IDLE;
            end
            S_FLUSH: begin
                out_vld  = 1'b1;
                out_data = r_x[OUT_WIDTH-1:0];
                out_last = (r_cnt == FL_LAST);
                if (out_rdy && (r_cnt == FL_LAST)) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_x      <= L_VAL;
            r_ptr    <= '0;
            r_acc    <= '0;
            r_sym    <= '0;
            r_q      <= '0;
            r_rem    <= '0;
            r_cnt    <= '0;
            r_tbl_ok <= 1'b0;
            r_err    <= 1'b0;
            for (int unsigned i = 0; i < N; i++) begin
                r_f[i] <= '0;
                r_c[i] <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE, S_LOAD: begin
                    if (w_in_fire) begin
                        case (cmd)
                            2'b00: begin
                                r_x   <= L_VAL;
                                r_ptr <= '0;
                                r_err <= 1'b0;
                            end
                            2'b01: begin
                                r_ptr <= '0;
                                if (w_enc_ok) begin
                                    r_sym <= w_enc_sym;
                                end else begin
                                    r_err <= 1'b1;
                                end
                            end
                            2'b10: begin
                                r_ptr <= '0;
                                r_cnt <= '0;
                            end
                            default: begin
                                // Pointer wraps to 0 after the last entry,
                                // which is where the prefix sum starts.
                                r_f[r_ptr] <= in_data[FW-1:0];
                                r_ptr      <= r_ptr + SYM_WIDTH'(1);
                                r_tbl_ok   <= 1'b0;
                                r_acc      <= '0;
                            end
                        endcase
                    end
                end
                S_CUMSUM: begin
                    r_c[r_ptr] <= r_acc[FW-1:0];
                    r_acc      <= w_acc_sum;
                    r_ptr      <= r_ptr + SYM_WIDTH'(1);
                    if (r_ptr == PTR_LAST) begin
                        r_tbl_ok <= (w_acc_sum == M_VAL);
                        if (w_acc_sum != M_VAL) begin
                            r_err <= 1'b1;
                        end
                    end
                end
                S_RENORM: begin
                    if (w_renorm) begin
                        if (out_rdy) begin
                            r_x <= r_x >> OUT_WIDTH;
                        end
                    end else begin
                        r_q   <= r_x;
                        r_rem <= '0;
                        r_cnt <= '0;
                    end
                end
                S_DIV: begin
                    r_q   <= {r_q[STATE_WIDTH-2:0], w_ge};
                    r_rem <= w_ge ? w_trial_sub[FW-1:0] : w_trial[FW-1:0];
                    r_cnt <= r_cnt + CNTW'(1);
                end
                S_UPDATE: begin
                    r_x <= w_upd;
                end
                S_FLUSH: begin
                    if (out_rdy) begin
                        r_cnt <= r_cnt + CNTW'(1);
                        r_x   <= (r_cnt == FL_LAST) ? L_VAL : (r_x >> OUT_WIDTH);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ans_rans_encoder.sv
module tb_ans_rans_encoder;

    localparam int unsigned LV = 4096;
    localparam int unsigned MM = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] cmd = 2'b00;
    logic [7:0] in_data = '0;
    logic       in_vld = 1'b0;
    logic       in_rdy;
    logic [3:0] out_data;
    logic       out_vld;
    logic       out_rdy = 1'b1;
    logic       out_last;
    logic       tbl_ok;
    logic       err;

    always #5 clk = ~clk;

    ans_rans_encoder #(
        .SYM_WIDTH  (4),
        .PREC       (4),
        .STATE_WIDTH(16),
        .OUT_WIDTH  (4),
        .IN_WIDTH   (8)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .cmd     (cmd),
        .in_data (in_data),
        .in_vld  (in_vld),
        .in_rdy  (in_rdy),
        .out_data(out_data),
        .out_vld (out_vld),
        .out_rdy (out_rdy),
        .out_last(out_last),
        .tbl_ok  (tbl_ok),
        .err     (err)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state: plain integers, state value, table and flags.
    int unsigned mx;
    int unsigned mf [16];
    int unsigned mc [16];
    bit          m_ok;
    bit          m_err;
    int unsigned mp;

    int exp_d[$];
    bit exp_l[$];
    int got_d[$];
    bit got_l[$];
    int last_lat;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        mx = LV; m_ok = 0; m_err = 0; mp = 0;
        for (int i = 0; i < 16; i++) begin
            mf[i] = 0;
            mc[i] = 0;
        end
    endtask

    task automatic model_apply(input int c, input int unsigned d);
        int unsigned s, xmax, sum;
        exp_d.delete();
        exp_l.delete();
        case (c)
            0: begin mx = LV; mp = 0; m_err = 0; end
            1: begin
                mp = 0;
                s = d % 16;
                if (!m_ok || mf[s] == 0) begin
                    m_err = 1;
                end else begin
                    xmax = mf[s] * LV;
                    while (mx >= xmax) begin
                        exp_d.push_back(int'(mx % 16));
                        exp_l.push_back(1'b0);
                        mx = mx / 16;
                    end
                    mx = (mx / mf[s]) * MM + (mx % mf[s]) + mc[s];
                end
            end
            2: begin
                mp = 0;
                for (int k = 0; k < 4; k++) begin
                    exp_d.push_back(int'(mx % 16));
                    exp_l.push_back(k == 3);
                    mx = mx / 16;
                end
                mx = LV;
            end
            default: begin
                mf[mp] = d % 32;
                mp++;
                m_ok = 0;
                if (mp == 16) begin
                    sum = 0;
                    for (int i = 0; i < 16; i++) begin
                        mc[i] = sum;
                        sum += mf[i];
                    end
                    m_ok = (sum == MM);
                    if (!m_ok) m_err = 1;
                    mp = 0;
                end
            end
        endcase
    endtask

    task automatic send(input logic [1:0] c, input logic [7:0] d);
        int n;
        cmd = c; in_data = d; in_vld = 1'b1;
        n = 0;
        while (!in_rdy && n < 100) begin
            tick();
            n++;
        end
        check("accept_rdy", in_rdy, 1);
        tick();
        in_vld = 1'b0;
    endtask

    // Drain digits until the block is ready again; checks output stability
    // under backpressure and that out_last is qualified by out_vld.
    task automatic run_out(input bit rand_rdy);
        int   n;
        bit   prev_hold;
        logic [3:0] prev_d;
        logic prev_l;
        got_d.delete();
        got_l.delete();
        n = 0; prev_hold = 0; prev_d = '0; prev_l = 1'b0;
        while (!in_rdy && n < 400) begin
            out_rdy = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            if (prev_hold) begin
                check("hold_vld", out_vld, 1);
                check("hold_data", out_data, prev_d);
                check("hold_last", out_last, prev_l);
            end
            if (!out_vld) check("last_unqual", out_last, 0);
            if (out_vld && out_rdy) begin
                got_d.push_back(int'(out_data));
                got_l.push_back(out_last);
            end
            prev_hold = out_vld && !out_rdy;
            prev_d = out_data;
            prev_l = out_last;
            tick();
            n++;
        end
        out_rdy = 1'b1;
        last_lat = n;
        check("idle_timeout", in_rdy, 1);
    endtask

    task automatic compare(input string tag);
        int n;
        check({tag, "_ndig"}, got_d.size(), exp_d.size());
        n = (got_d.size() < exp_d.size()) ? got_d.size() : exp_d.size();
        for (int i = 0; i < n; i++) begin
            check({tag, "_dig"}, got_d[i], exp_d[i]);
            check({tag, "_last"}, got_l[i], exp_l[i]);
        end
        check({tag, "_tbl_ok"}, tbl_ok, m_ok);
        check({tag, "_err"}, err, m_err);
    endtask

    task automatic txn(input int c, input int unsigned d, input bit rr, input string tag);
        model_apply(c, d);
        send(2'(c), 8'(d));
        run_out(rr);
        compare(tag);
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned tf [16];
        model_reset();

        // Reset values
        repeat (3) tick();
        check("rst_in_rdy", in_rdy, 0);
        check("rst_out_vld", out_vld, 0);
        check("rst_out_last", out_last, 0);
        check("rst_out_data", out_data, 0);
        check("rst_tbl_ok", tbl_ok, 0);
        check("rst_err", err, 0);
        rst = 1'b0;
        tick();
        check("post_rst_rdy", in_rdy, 1);

        // Uniform table, encode 3, flush
        txn(0, 0, 0, "clr");
        for (int i = 0; i < 16; i++) txn(3, 1, 0, "ld_uni");
        check("cumsum_cycles", last_lat, 16);
        txn(1, 3, 0, "enc_s3");
        txn(2, 0, 0, "flush_4099");

        // Single-symbol table, no-renorm latency, zero-frequency symbol
        txn(0, 0, 0, "clr");
        for (int i = 0; i < 16; i++) txn(3, (i == 0) ? 16 : 0, 0, "ld_one");
        txn(1, 0, 0, "enc_s0");
        check("enc_latency", last_lat, 18);
        txn(2, 0, 0, "flush_4096");
        txn(1, 1, 0, "enc_f0");
        check("drop_rdy", in_rdy, 1);

        // Bad sum table
        for (int i = 0; i < 16; i++) txn(3, 2, 0, "ld_bad");
        txn(1, 0, 0, "enc_badtbl");
        txn(0, 0, 0, "clr_err");

        // Backpressure on a renorm digit
        for (int i = 0; i < 16; i++) txn(3, 1, 0, "ld_uni2");
        txn(0, 0, 0, "clr");
        model_apply(1, 3);
        send(2'b01, 8'd3);
        out_rdy = 1'b0;
        for (int n = 0; n < 20 && !out_vld; n++) tick();
        check("bp_vld_seen", out_vld, 1);
        for (int k = 0; k < 5; k++) begin
            check("bp_vld", out_vld, 1);
            check("bp_data", out_data, 0);
            check("bp_in_rdy", in_rdy, 0);
            tick();
        end
        run_out(0);
        compare("bp_enc");
        txn(2, 0, 0, "bp_flush");

        // Reset in the middle of the division
        txn(0, 0, 0, "clr");
        model_apply(1, 5);
        send(2'b01, 8'd5);
        repeat (8) tick();
        rst = 1'b1;
        #1;
        check("mid_rst_in_rdy", in_rdy, 0);
        check("mid_rst_out_vld", out_vld, 0);
        check("mid_rst_out_last", out_last, 0);
        check("mid_rst_out_data", out_data, 0);
        check("mid_rst_tbl_ok", tbl_ok, 0);
        check("mid_rst_err", err, 0);
        tick();
        rst = 1'b0;
        model_reset();
        tick();
        check("mid_rst_rdy_after", in_rdy, 1);
        txn(2, 0, 0, "flush_after_rst");

        // Randomised tables and symbol streams with random backpressure
        for (int r = 0; r < 5; r++) begin
            for (int i = 0; i < 16; i++) tf[i] = 0;
            if (r == 4) begin
                for (int i = 0; i < 16; i++) tf[i] = $urandom_range(0, 2);
            end else begin
                for (int u = 0; u < 16; u++) tf[$urandom_range(0, 15)]++;
            end
            txn(0, 0, 1, "rnd_clr");
            for (int i = 0; i < 16; i++)
                txn(3, tf[i] | ($urandom_range(0, 7) << 5), 1, "rnd_ld");
            for (int e = 0; e < 14; e++) begin
                txn(1, $urandom_range(0, 255), 1, "rnd_enc");
                if (e % 5 == 4) txn(2, 0, 1, "rnd_flush");
            end
            txn(2, 0, 1, "rnd_flush_end");
        end

        // Encode issued mid-load aborts the load and is rejected
        txn(3, 4, 0, "abort_ld");
        txn(1, 2, 0, "abort_enc");
        txn(2, 0, 0, "abort_flush");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ans_rans_encoder.md
ANS_RANS_ENCODER -- requirements
Module: ans_rans_encoder

Interface
REQ-001 Parameter SYM_WIDTH, default 4, symbol width; alphabet size N = 2^SYM_WIDTH.
REQ-002 Parameter PREC, default 4, precision; frequencies SHALL sum to M = 2^PREC; frequency/cumulative width FW = PREC+1.
REQ-003 Parameter STATE_WIDTH, default 16, coder state width; L = 2^(STATE_WIDTH-OUT_WIDTH).
REQ-004 Parameter OUT_WIDTH, default 4, output digit width; STATE_WIDTH SHALL be a multiple of OUT_WIDTH and STATE_WIDTH-OUT_WIDTH >= PREC.
REQ-005 Parameter IN_WIDTH, default 8, input data width; IN_WIDTH >= max(SYM_WIDTH, FW).
REQ-006 One clock; reset is asynchronous and active-high.
REQ-007 clk  input  1  clock, all state on rising edge.
REQ-008 rst  input  1  asynchronous active-high reset.
REQ-009 cmd  input  2  per-transaction command, sampled with in_data: 00 clear, 01 encode, 10 flush, 11 load.
REQ-010 in_data  input  IN_WIDTH  symbol (low SYM_WIDTH bits) or frequency (low FW bits); upper bits ignored.
REQ-011 in_vld  input  1  input transaction valid.
REQ-012 in_rdy  output  1  block accepts a transaction this cycle.
REQ-013 out_data  output  OUT_WIDTH  emitted state digit.
REQ-014 out_vld  output  1  out_data valid.
REQ-015 out_rdy  input  1  downstream accepts digit.
REQ-016 out_last  output  1  qualifies final digit of a flush.
REQ-017 tbl_ok  output  1  table loaded and sum equals M.
REQ-018 err  output  1  sticky error.

Function
REQ-019 Transaction handshake = in_vld & in_rdy on a rising edge; in_rdy SHALL be 1 only in IDLE or LOAD.
REQ-020 States: IDLE, LOAD, CUMSUM, RENORM, DIV, UPDATE, FLUSH.
REQ-021 cmd 00: x := L, load pointer := 0, err := 0, tbl_ok unchanged; stays IDLE; one cycle.
REQ-022 cmd 11: f[ptr] := in_data[FW-1:0], ptr += 1, tbl_ok := 0, state LOAD; on write of entry N-1 go to CUMSUM; cmd other than 11 accepted in LOAD aborts load (ptr := 0, tbl_ok stays 0) and is executed.
REQ-023 CUMSUM: one entry per cycle, N cycles, c[0]=0, c[i]=c[i-1]+f[i-1]; total accumulated in PREC+SYM_WIDTH+1 bits (no wrap); then tbl_ok := (total == M), err := 1 if total != M; return to IDLE.
REQ-024 cmd 01 with tbl_ok=0 or f[s]=0: symbol dropped, err := 1, state unchanged, no output.
REQ-025 cmd 01 valid: RENORM while x >= x_max, x_max = f[s] << (STATE_WIDTH-PREC) computed in STATE_WIDTH+1 bits; each iteration presents out_data = x[OUT_WIDTH-1:0], out_vld=1, and on out_rdy x := x >> OUT_WIDTH.
REQ-026 DIV: restoring division x / f[s], exactly STATE_WIDTH cycles, yields q, r.
REQ-027 UPDATE: x := (q << PREC) + r + c[s], one cycle, then IDLE; result SHALL lie in [L, 2^STATE_WIDTH).
REQ-028 Latency: with no renorm digits, in_rdy reasserts exactly STATE_WIDTH+2 cycles after the accept edge; each renorm digit adds >= 1 cycle.
REQ-029 cmd 10: FLUSH emits STATE_WIDTH/OUT_WIDTH digits of x, least-significant first, out_last=1 on the last; then x := L, IDLE; flush with tbl_ok=0 still allowed.
REQ-030 Output stability: while out_vld=1 and out_rdy=0, out_data, out_last, out_vld SHALL hold; out_vld SHALL not drop without a handshake.
REQ-031 out_last SHALL be 0 whenever out_vld=0 or outside FLUSH.
REQ-032 in_rdy=0 whenever out_vld=1; simultaneous events impossible by construction.

Reset
REQ-033 rst=1 asynchronously forces IDLE, x=L, ptr=0, f[]=0, c[]=0, tbl_ok=0, err=0, in_rdy=0 while asserted, out_vld=0, out_last=0, out_data=0.
REQ-034 Reset mid-DIV, mid-RENORM or mid-FLUSH SHALL discard the operation; in_rdy=1 on the first edge after deassertion.

Verification
REQ-035 Load f[i]=1 for all 16 -> tbl_ok=1 after 16 CUMSUM cycles; encode s=3 -> one digit 0, then x=4099; flush -> digits 3,0,0,1 with out_last on 1; x=4096.
REQ-036 Load f[0]=16, rest 0 -> tbl_ok=1; encode s=0 -> no digits, x=4096, in_rdy back after 18 cycles; encode s=1 -> err=1, no output.
REQ-037 Load all f=2 (sum 32) -> tbl_ok=0, err=1; encode s=0 -> dropped; cmd 00 -> err=0.
REQ-038 Uniform table, out_rdy=0 for 5 cycles during renorm digit -> out_data=0, out_vld=1 held stable; resumes on out_rdy=1.
REQ-039 Assert rst during DIV cycle 7 -> all outputs reset values; after release, flush emits 0,0,0,1 (x=4096).
